timer_display: RTL and testbench

Downstream display stage for the countdown timer. Takes the timer's binary `min_i`/`sec_i` values and drives a 4-digit, common-anode, time-multiplexed 7-segment display as MM.SS. Inputs come from the timer's slow clock domain, so they are stability-filtered before use. When the count reaches 00:00 the display blinks.

---
 rtl/timer_pkg.sv | 55 +++++
 rtl/seg7_decode.sv | 28 ++
 rtl/timer_display.sv | 177 +++++++++++++++++
 tb/tb_timer_display.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants and types for the countdown timer display path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package timer_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digit code that the decoder renders as all segments off.
  localparam logic [3:0] BLANK_CODE = 4'd15;

  // Digit slot index; slot 0 is the rightmost digit.
  typedef logic [1:0] digit_idx_t;

  localparam digit_idx_t IDX_SEC_ONES = 2'd0;
  localparam digit_idx_t IDX_SEC_TENS = 2'd1;
  localparam digit_idx_t IDX_MIN_ONES = 2'd2;
  localparam digit_idx_t IDX_MIN_TENS = 2'd3;

  // One-cold anode patterns (active-low anodes).
  localparam logic [3:0] AN_DIG0 = 4'b1110;
  localparam logic [3:0] AN_DIG1 = 4'b1101;
  localparam logic [3:0] AN_DIG2 = 4'b1011;
  localparam logic [3:0] AN_DIG3 = 4'b0111;
  localparam logic [3:0] AN_NONE = 4'b1111;

  // Tens/ones pair produced by the BCD split.
  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  // Anode pattern that lights exactly the selected digit.
  function automatic logic [3:0] anode_for(input digit_idx_t idx);
    logic [3:0] an;
    case (idx)
      IDX_SEC_ONES: an = AN_DIG0;
      IDX_SEC_TENS: an = AN_DIG1;
      IDX_MIN_ONES: an = AN_DIG2;
      default:      an = AN_DIG3;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Maps a 4-bit digit code to active-low 7-segment drive; codes 10..15 are blank.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of the code input.
module seg7_decode (
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);
  import timer_pkg::*;

  // Lookup of the segment pattern for the selected code.
  always_comb begin
    seg_o = SEG_BLANK;
    case (code_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/timer_display.sv
// Filters MM:SS from the timer, splits to BCD and scans a 4-digit common-anode display; blinks at 00:00.
// Latency: input stable 2 edges -> shown, +1 edge -> digit regs, shown on the next slot that selects the digit.
// Backpressure: none; inputs are sampled every cycle and the display free-runs.
module timer_display #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_TICKS = 256
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [5:0] sec_i,
  input  logic [5:0] min_i,
  output logic [3:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o
);
  import timer_pkg::*;

  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_TICKS - 1);

  // Divide-free tens/ones split; the weighted compare/subtract chain
  // covers the full 0..63 input range (tens never exceeds 6).
  function automatic bcd_t bcd_split(input logic [5:0] value);
    logic [5:0] rem;
    logic [3:0] tens;
    bcd_t       res;
    rem  = value;
    tens = 4'd0;
    if (rem >= 6'd40) begin
      rem  = rem - 6'd40;
      tens = tens + 4'd4;
    end
    if (rem >= 6'd20) begin
      rem  = rem - 6'd20;
      tens = tens + 4'd2;
    end
    if (rem >= 6'd10) begin
      rem  = rem - 6'd10;
      tens = tens + 4'd1;
    end
    res.tens = tens;
    res.ones = 4'(rem);
    return res;
  endfunction

  // Input filter state.
  logic [11:0]      samp_q;
  logic [5:0]       shown_min_q, shown_min_d;
  logic [5:0]       shown_sec_q, shown_sec_d;

  // Per-digit codes, index 0 = seconds ones.
  logic [3:0][3:0]  digit_q, digit_d;
  bcd_t             sec_bcd, min_bcd;

  // Scan and blink state.
  logic [RW-1:0]    refresh_cnt_q, refresh_cnt_d;
  digit_idx_t       idx_q, idx_d;
  logic [BW-1:0]    blink_cnt_q, blink_cnt_d;
  logic             blink_off_q, blink_off_d;
  logic             wrap;
  logic             expired_d;
  logic             slot_load;

  // Registered display drive.
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [6:0]       dec_seg;

  // Accept a new value only when it matches last cycle's sample, so a
  // one-cycle glitch from the slow domain never reaches the display.
  always_comb begin
    shown_min_d = shown_min_q;
    shown_sec_d = shown_sec_q;
    if ({min_i, sec_i} == samp_q) begin
      shown_min_d = min_i;
      shown_sec_d = sec_i;
    end
  end

  // Split the accepted value into digit codes; a zero minutes-tens is blanked.
  always_comb begin
    sec_bcd    = bcd_split(shown_sec_q);
    min_bcd    = bcd_split(shown_min_q);
    digit_d[0] = sec_bcd.ones;
    digit_d[1] = sec_bcd.tens;
    digit_d[2] = min_bcd.ones;
    digit_d[3] = (min_bcd.tens == 4'd0) ? BLANK_CODE : min_bcd.tens;
  end

  // Slot timer: idx moves on the cycle the refresh counter wraps.
  always_comb begin
    wrap          = (refresh_cnt_q == REFRESH_LAST);
    refresh_cnt_d = wrap ? '0 : refresh_cnt_q + 1'b1;
    idx_d         = wrap ? idx_q + 2'd1 : idx_q;
  end

  // Blink phase. Expiry is judged on the value being loaded into shown_*,
  // so leaving 00:00 clears the blink state on the same edge as the update.
  always_comb begin
    expired_d   = (shown_min_d == 6'd0) && (shown_sec_d == 6'd0);
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    if (!expired_d) begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
    end else if (wrap) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  seg7_decode u_seg7_decode (
    .code_i (digit_q[idx_q]),
    .seg_o  (dec_seg)
  );

  // Render a slot once, on its first cycle; the rest of the slot holds it so
  // a mid-slot change waits for the next slot that selects that digit.
  always_comb begin
    slot_load = (refresh_cnt_q == '0);
    an_d      = an_q;
    seg_d     = seg_q;
    dp_d      = dp_q;
    if (slot_load) begin
      if (blink_off_q) begin
        an_d  = AN_NONE;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
      end else begin
        an_d  = anode_for(idx_q);
        seg_d = dec_seg;
        dp_d  = (idx_q != IDX_MIN_ONES);
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      samp_q        <= '0;
      shown_min_q   <= '0;
      shown_sec_q   <= '0;
      digit_q       <= {BLANK_CODE, 4'd0, 4'd0, 4'd0};
      refresh_cnt_q <= '0;
      idx_q         <= IDX_SEC_ONES;
      blink_cnt_q   <= '0;
      blink_off_q   <= 1'b0;
      an_q          <= AN_NONE;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
    end else begin
      samp_q        <= {min_i, sec_i};
      shown_min_q   <= shown_min_d;
      shown_sec_q   <= shown_sec_d;
      digit_q       <= digit_d;
      refresh_cnt_q <= refresh_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_off_q   <= blink_off_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;
  assign dp_o  = dp_q;

endmodule

// File: tb/tb_timer_display.sv
// Self-checking bench for timer_display with a behavioural display model.
// Latency: model tracks edges since reset and derives slot/blink by arithmetic.
// Backpressure: none.
module tb_timer_display;

  localparam int DIV = 4;
  localparam int BT  = 2;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [5:0] sec_i;
  logic [5:0] min_i;
  logic [3:0] an_o;
  logic [6:0] seg_o;
  logic       dp_o;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  timer_display #(.REFRESH_DIV(DIV), .BLINK_TICKS(BT)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .sec_i   (sec_i),
    .min_i   (min_i),
    .an_o    (an_o),
    .seg_o   (seg_o),
    .dp_o    (dp_o)
  );

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'h7F, 7'h7F,
                               7'h7F, 7'h7F, 7'h7F, 7'h7F};

  // Reference model: values kept as min*64+sec.
  int m_n;      // clock edges since reset release
  int m_samp;   // previous cycle's input
  int m_shown;  // accepted value
  int m_dig;    // value the digit registers currently reflect
  int m_adv;    // digit advances since the count became 00:00
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;

  task automatic tick();
    int in_v, slot, mn, sc, d;
    @(posedge clk_i);
    in_v = int'(min_i) * 64 + int'(sec_i);
    if (reset_i) begin
      m_n = 0; m_samp = 0; m_shown = 0; m_dig = 0; m_adv = 0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      if (m_n % DIV == 0) begin
        slot = (m_n / DIV) % 4;
        mn = m_dig / 64;
        sc = m_dig % 64;
        if ((m_adv / BT) % 2 == 1) begin
          e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
          case (slot)
            0:       d = sc % 10;
            1:       d = sc / 10;
            2:       d = mn % 10;
            default: d = (mn / 10 == 0) ? 15 : mn / 10;
          endcase
          e_an = 4'hF;
          e_an[slot] = 1'b0;
          e_seg = seg_tab[d];
          e_dp = (slot != 2);
        end
      end
      m_dig = m_shown;
      if (in_v == m_samp) m_shown = in_v;
      m_samp = in_v;
      m_n++;
      if (m_shown != 0) m_adv = 0;
      else if (m_n % DIV == 0) m_adv++;
    end
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; min_i = 6'd4; sec_i = 6'd37;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({an_o, seg_o, dp_o} !== {4'b1111, 7'b1111111, 1'b1}) begin
        miscompares++;
        $display("FAIL reset_outputs cyc=%0d got an=%b seg=%b dp=%b want an=1111 seg=1111111 dp=1", i, an_o, seg_o, dp_o);
      end
    end
  endtask

  task automatic test_basic_scan();
    logic [3:0] an_exp [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] seg_exp [4] = '{7'b1111000, 7'b0110000, 7'b0011001, 7'b1111111};
    logic       dp_exp [4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    reset_i = 1'b0;
    for (int i = 0; i < 4 * DIV; i++) begin
      tick();
      vectors++;
      if ({an_o, seg_o, dp_o} !== {e_an, e_seg, e_dp}) begin
        miscompares++;
        $display("FAIL scan_model n=%0d got %b/%b/%b want %b/%b/%b", m_n, an_o, seg_o, dp_o, e_an, e_seg, e_dp);
      end
    end
    for (int s = 0; s < 4; s++) begin
      tick();
      vectors++;
      if ({an_o, seg_o, dp_o} !== {an_exp[s], seg_exp[s], dp_exp[s]}) begin
        miscompares++;
        $display("FAIL scan_slot%0d got %b/%b/%b want %b/%b/%b", s, an_o, seg_o, dp_o, an_exp[s], seg_exp[s], dp_exp[s]);
      end
      for (int i = 1; i < DIV; i++) begin
        tick();
        vectors++;
        if ({an_o, seg_o, dp_o} !== {e_an, e_seg, e_dp}) begin
          miscompares++;
          $display("FAIL scan_hold n=%0d got %b/%b/%b want %b/%b/%b", m_n, an_o, seg_o, dp_o, e_an, e_seg, e_dp);
        end
      end
    end
  endtask

  task automatic test_glitch();
    bit seen_six = 0;
    sec_i = 6'd36;
    tick();
    sec_i = 6'd37;
    for (int i = 0; i < 8 * DIV; i++) begin
      tick();
      vectors++;
      if ({an_o, seg_o, dp_o} !== {e_an, e_seg, e_dp}) begin
        miscompares++;
        $display("FAIL glitch_model n=%0d got %b/%b/%b want %b/%b/%b", m_n, an_o, seg_o, dp_o, e_an, e_seg, e_dp);
      end
      if (an_o == 4'b1110 && seg_o == 7'b0000010) seen_six = 1;
    end
    vectors++;
    if (seen_six !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_shown got seen=%0d want 0", seen_six);
    end
    sec_i = 6'd36;
    for (int i = 0; i < 8 * DIV; i++) begin
      tick();
      vectors++;
      if ({an_o, seg_o, dp_o} !== {e_an, e_seg, e_dp}) begin
        miscompares++;
        $display("FAIL hold36_model n=%0d got %b/%b/%b want %b/%b/%b", m_n, an_o, seg_o, dp_o, e_an, e_seg, e_dp);
      end
      if (an_o == 4'b1110 && seg_o == 7'b0000010) seen_six = 1;
    end
    vectors++;
    if (seen_six !== 1'b1) begin
      miscompares++;
      $display("FAIL hold36_shown got seen=%0d want 1", seen_six);
    end
  endtask

  task automatic test_tens();
    bit seen_mt = 0, seen_nine = 0;
    min_i = 6'd10; sec_i = 6'd9;
    for (int i = 0; i < 8 * DIV; i++) begin
      tick();
      vectors++;
      if ({an_o, seg_o, dp_o} !== {e_an, e_seg, e_dp}) begin
        miscompares++;
        $display("FAIL tens_model n=%0d got %b/%b/%b want %b/%b/%b", m_n, an_o, seg_o, dp_o, e_an, e_seg, e_dp);
      end
      if (an_o == 4'b0111 && seg_o == 7'b1111001) seen_mt = 1;
      if (an_o == 4'b1110 && seg_o == 7'b0010000) seen_nine = 1;
    end
    vectors++;
    if ({seen_mt, seen_nine} !== 2'b11) begin
      miscompares++;
      $display("FAIL tens_digits got min_tens=%0d sec_ones9=%0d want 1 1", seen_mt, seen_nine);
    end
  endtask

  task automatic test_expired();
    int dark;
    min_i = 6'd0; sec_i = 6'd0;
    for (int i = 0; i < 3 * DIV; i++) tick();
    while (m_n % DIV != 0) tick();
    dark = 0;
    for (int i = 0; i < 16 * DIV; i++) begin
      tick();
      vectors++;
      if ({an_o, seg_o, dp_o} !== {e_an, e_seg, e_dp}) begin
        miscompares++;
        $display("FAIL blink_model n=%0d got %b/%b/%b want %b/%b/%b", m_n, an_o, seg_o, dp_o, e_an, e_seg, e_dp);
      end
      if (an_o == 4'b1111) dark++;
    end
    vectors++;
    if (dark != 8 * DIV) begin
      miscompares++;
      $display("FAIL blink_dark_cycles got %0d want %0d", dark, 8 * DIV);
    end
    sec_i = 6'd5;
    for (int i = 0; i < 3 * DIV; i++) tick();
    dark = 0;
    for (int i = 0; i < 16 * DIV; i++) begin
      tick();
      vectors++;
      if ({an_o, seg_o, dp_o} !== {e_an, e_seg, e_dp}) begin
        miscompares++;
        $display("FAIL unexpire_model n=%0d got %b/%b/%b want %b/%b/%b", m_n, an_o, seg_o, dp_o, e_an, e_seg, e_dp);
      end
      if (an_o == 4'b1111) dark++;
    end
    vectors++;
    if (dark != 0) begin
      miscompares++;
      $display("FAIL unexpire_dark_cycles got %0d want 0", dark);
    end
  endtask

  task automatic test_reset_midscan();
    bit found = 0;
    for (int i = 0; i < 8 * DIV && !found; i++) begin
      tick();
      if (an_o == 4'b1011) found = 1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL midscan_find_idx2 got an=%b want 1011 within %0d cycles", an_o, 8 * DIV);
    end
    reset_i = 1'b1;
    tick();
    vectors++;
    if ({an_o, seg_o, dp_o} !== {4'b1111, 7'b1111111, 1'b1}) begin
      miscompares++;
      $display("FAIL midscan_reset got %b/%b/%b want 1111/1111111/1", an_o, seg_o, dp_o);
    end
    reset_i = 1'b0;
    tick();
    vectors++;
    if (an_o !== 4'b1110) begin
      miscompares++;
      $display("FAIL midscan_restart got an=%b want 1110", an_o);
    end
    for (int i = 0; i < 8 * DIV; i++) begin
      tick();
      vectors++;
      if ({an_o, seg_o, dp_o} !== {e_an, e_seg, e_dp}) begin
        miscompares++;
        $display("FAIL midscan_model n=%0d got %b/%b/%b want %b/%b/%b", m_n, an_o, seg_o, dp_o, e_an, e_seg, e_dp);
      end
    end
  endtask

  task automatic test_out_of_range();
    bit seen6 = 0, seen3 = 0;
    min_i = 6'd7; sec_i = 6'd63;
    for (int i = 0; i < 8 * DIV; i++) begin
      tick();
      vectors++;
      if ({an_o, seg_o, dp_o} !== {e_an, e_seg, e_dp}) begin
        miscompares++;
        $display("FAIL range_model n=%0d got %b/%b/%b want %b/%b/%b", m_n, an_o, seg_o, dp_o, e_an, e_seg, e_dp);
      end
      if (an_o == 4'b1101 && seg_o == 7'b0000010) seen6 = 1;
      if (an_o == 4'b1110 && seg_o == 7'b0110000) seen3 = 1;
    end
    vectors++;
    if ({seen6, seen3} !== 2'b11) begin
      miscompares++;
      $display("FAIL range_63 got tens6=%0d ones3=%0d want 1 1", seen6, seen3);
    end
  endtask

  task automatic test_random();
    int hold;
    for (int seg_n = 0; seg_n < 300; seg_n++) begin
      reset_i = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) begin
        min_i = 6'd0; sec_i = 6'd0;
        hold = int'($urandom_range(10, 30));
      end else begin
        min_i = 6'($urandom_range(0, 63));
        sec_i = 6'($urandom_range(0, 63));
        hold = int'($urandom_range(1, 6));
      end
      for (int i = 0; i < hold; i++) begin
        tick();
        reset_i = 1'b0;
        vectors++;
        if ({an_o, seg_o, dp_o} !== {e_an, e_seg, e_dp}) begin
          miscompares++;
          $display("FAIL random_model n=%0d got %b/%b/%b want %b/%b/%b", m_n, an_o, seg_o, dp_o, e_an, e_seg, e_dp);
        end
      end
    end
  endtask

  initial begin
    reset_i = 1'b1;
    min_i   = 6'd0;
    sec_i   = 6'd0;
    test_reset();
    test_basic_scan();
    test_glitch();
    test_tens();
    test_expired();
    test_reset_midscan();
    test_out_of_range();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
